// File: rtl/edram_arbiter.sv
`default_nettype none
// ============================================================================
// edram_arbiter : round-robin arbiter sharing one fixed-latency eDRAM port
//                 among NUM_IMA requesters, one access in flight at a time.
// Revision 1.0
// ============================================================================
module edram_arbiter #(
  parameter int NUM_IMA    = 4,
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 12,
  parameter int MEM_LAT    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IMA-1:0]            ima_ren_i,
  input  logic [NUM_IMA-1:0]            ima_wen_i,
  input  logic [NUM_IMA*ADDR_WIDTH-1:0] ima_addr_i,
  input  logic [NUM_IMA*DATA_WIDTH-1:0] ima_wdata_i,
  output logic [NUM_IMA-1:0]            ima_wait_o,
  output logic [DATA_WIDTH-1:0]         ima_rdata_o,
  output logic                          ram_ren_o,
  output logic                          ram_wen_o,
  output logic [ADDR_WIDTH-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_IMA)-1:0]    grant_id_o
);

  localparam int c_GNT_W = $clog2(NUM_IMA);
  localparam int c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [0:0] {
    FREE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [c_CNT_W-1:0]    cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [c_GNT_W-1:0]    last_grant_q, last_grant_d;
  logic [c_GNT_W-1:0]    grant_id_q, grant_id_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NUM_IMA-1:0]    w_req;
  logic [NUM_IMA-1:0]    w_mreq;
  logic                  w_pick_vld;
  logic [c_GNT_W-1:0]    w_pick;
  int                    w_idx;

  assign w_req = ima_ren_i | ima_wen_i;

  for (genvar i = 0; i < NUM_IMA; i++) begin : g_wait
    assign ima_wait_o[i] = w_req[i] & ~(done_q & (grant_id_q == c_GNT_W'(i)));
  end

  // The stall vector is exactly the request vector with the just-completed
  // port masked, so it doubles as the arbitration input.
  assign w_mreq = ima_wait_o;

  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_idx      = 0;
    for (int k = 1; k <= NUM_IMA; k++) begin
      w_idx = (int'(last_grant_q) + k) % NUM_IMA;
      if (!w_pick_vld && w_mreq[c_GNT_W'(w_idx)]) begin
        w_pick_vld = 1'b1;
        w_pick     = c_GNT_W'(w_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    case (state_q)
      FREE: begin
        if (w_pick_vld) begin
          state_d      = BUSY;
          grant_id_d   = w_pick;
          last_grant_d = w_pick;
          wr_d         = ima_wen_i[w_pick];
          addr_d       = ima_addr_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d      = ima_wdata_i[w_pick*DATA_WIDTH +: DATA_WIDTH];
          cnt_d        = c_CNT_W'(MEM_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = FREE;
          done_d  = 1'b1;
          if (!wr_q) begin
            rdata_d = ram_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FREE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      last_grant_q <= c_GNT_W'(NUM_IMA - 1);
      grant_id_q   <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign busy_o      = (state_q == BUSY);
  assign ram_ren_o   = busy_o & ~wr_q;
  assign ram_wen_o   = busy_o & wr_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ima_rdata_o = rdata_q;
  assign grant_id_o  = grant_id_q;

endmodule
`default_nettype wire

// File: doc/edram_arbiter.md
EDRAM_ARBITER -- requirements
Module: edram_arbiter

Interface
REQ-001 The block SHALL have the parameter NUM_IMA, default 4, giving the number of IMA request ports; legal values are 2 or more.
REQ-002 The block SHALL have the parameter ADDR_WIDTH, default 20, giving the eDRAM address width.
REQ-003 The block SHALL have the parameter DATA_WIDTH, default 12, giving the data word width (data plus counter field).
REQ-004 The block SHALL have the parameter MEM_LAT, default 4, giving the eDRAM access latency in cycles; legal values are 1 or more.
REQ-005 The block SHALL use one clock, and its reset SHALL be synchronous and active-high; ports are named clk and rst.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ima_ren  in  NUM_IMA  per-port read request.
REQ-009 ima_wen  in  NUM_IMA  per-port write request.
REQ-010 ima_addr  in  NUM_IMA x ADDR_WIDTH  per-port address.
REQ-011 ima_wdata  in  NUM_IMA x DATA_WIDTH  per-port write data.
REQ-012 ima_wait  out  NUM_IMA  per-port stall: 1 = request pending, not yet complete.
REQ-013 ima_rdata  out  DATA_WIDTH  read return word, shared by all ports.
REQ-014 ram_ren, ram_wen  out  1 each  eDRAM read and write strobes.
REQ-015 ram_addr  out  ADDR_WIDTH  eDRAM address.
REQ-016 ram_wdata  out  DATA_WIDTH  eDRAM write data.
REQ-017 ram_rdata  in  DATA_WIDTH  eDRAM read data, valid in the last cycle of BUSY.
REQ-018 busy  out  1  1 while the state is BUSY.
REQ-019 grant_id  out  clog2(NUM_IMA)  the port currently or most recently granted.

Function
REQ-020 A port's request SHALL be req[i] = ima_ren[i] | ima_wen[i]; when both are high, the access SHALL be a write.
REQ-021 The FSM SHALL have exactly two states, FREE and BUSY.
REQ-022 In FREE with at least one unmasked request, the next edge SHALL enter BUSY with a grant, and the following SHALL be latched:
- the granted port index;
- the op type (read or write);
- the port's ima_addr and ima_wdata;
- the latency counter, loaded with MEM_LAT-1.
REQ-023 Arbitration SHALL be round-robin: search from (last_grant+1) mod NUM_IMA upward with wrap, and the first requesting port wins; last_grant SHALL update on every grant.
REQ-024 In BUSY, outputs SHALL be driven from the latched registers for all MEM_LAT cycles:
- ram_addr and ram_wdata held steady;
- exactly one of ram_ren or ram_wen high.
REQ-025 In BUSY, the counter SHALL decrement each cycle; at the edge where the counter is 0, the block SHALL:
- return to FREE;
- capture ram_rdata into the rdata register (on reads only; writes leave it unchanged);
- set done_q = 1.
REQ-026 done_q SHALL be high for exactly one cycle; in that cycle, ima_wait[grant_id] = 0 and ima_rdata = the captured word.
REQ-027 ima_wait[i] SHALL equal req[i] & ~(done_q & grant_id==i), combinational; a port with no request SHALL see wait = 0.
REQ-028 In the done_q cycle, the completed port's request SHALL be masked from arbitration so a held request is not re-granted; other ports may be granted in that same cycle.
REQ-029 Uncontended latency SHALL be as follows: request seen in cycle 0 gives BUSY in cycles 1..MEM_LAT and wait low in cycle MEM_LAT+1.
REQ-030 Sustained throughput SHALL be one access per MEM_LAT+1 cycles.
REQ-031 Request, address and data changes during BUSY SHALL NOT affect the in-flight access.
REQ-032 A requester dropping its request during BUSY SHALL NOT abort the access; the access SHALL complete with done_q still pulsing.
REQ-033 MEM_LAT = 1 SHALL give exactly one BUSY cycle.
REQ-034 ram_ren and ram_wen SHALL be 0 in FREE.

Reset
REQ-035 While rst = 1 at an edge, the following SHALL be set: state FREE, counter 0, done_q 0, last_grant NUM_IMA-1, grant_id 0, rdata register 0.
REQ-036 The outputs SHALL take these values in the cycle after reset:
- ram_ren = ram_wen = 0;
- busy = 0;
- ima_rdata = 0;
- ima_wait = the raw request vector.
REQ-037 Reset during BUSY SHALL discard the in-flight access with no done_q pulse; the first post-reset grant SHALL go to the lowest-index requester.

Verification
REQ-038 Scenario: NUM_IMA=4, MEM_LAT=4; port 2 reads 0x00010 in cycle 0 with ram_rdata=0xABC in cycle 4 -> ram_ren=1 in cycles 1-4, ima_wait[2]=0 and ima_rdata=0xABC in cycle 5.
REQ-039 Scenario: all 4 ports request from cycle 0 and hold until each completes -> grants in order 0,1,2,3, with completions in cycles 5, 10, 15 and 20.
REQ-040 Scenario: port 1 writes addr 0x00003 with data 0x7FF while ren=1 as well -> ram_wen=1, ram_ren=0, ram_addr=0x00003 and ram_wdata=0x7FF for 4 cycles, then ima_wait[1]=0 for one cycle.
REQ-041 Scenario: port 0 holds its request past completion while port 3 waits -> port 3 is granted in the done_q cycle and port 0 is not re-granted back-to-back.
REQ-042 Scenario: rst pulsed in cycle 2 of a BUSY access -> busy=0, no done_q pulse, and the next requester among {1,3} granted is port 1.
REQ-043 Scenario: MEM_LAT=1 build; single read -> BUSY for one cycle, and wait low in cycle 2.
